// File: rtl/vid_tpg_timing.sv
// Video timing generator and test-pattern source for the gamma pipeline.
// Produces an active / front-porch / sync / back-porch raster carrying one of four
// patterns: colour bars, gradient, checker or solid colour.
// Optional feature: define TPG_SCROLL_EN to add a frame counter that scrolls
// the gradient and the colour bars from one frame to the next.
module vid_tpg_timing #(
    parameter int unsigned H_ACTIVE = 1280,
    parameter int unsigned H_FP     = 110,
    parameter int unsigned H_SYNC   = 40,
    parameter int unsigned H_BP     = 220,
    parameter int unsigned V_ACTIVE = 720,
    parameter int unsigned V_FP     = 5,
    parameter int unsigned V_SYNC   = 5,
    parameter int unsigned V_BP     = 20,
    parameter logic        HS_POL   = 1'b1,
    parameter logic        VS_POL   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_enable,
    input  logic [1:0]  i_pattern_sel,
    input  logic [23:0] i_solid_rgb,
    output logic [23:0] o_rgb888,
    output logic        o_vsync,
    output logic        o_hsync,
    output logic        o_vaild,
    output logic        o_sof
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // At least 8 bits so the gradient and checker bit selects are always in range
    localparam int unsigned HW      = ($clog2(H_TOTAL) > 8) ? $clog2(H_TOTAL) : 8;
    localparam int unsigned VW      = ($clog2(V_TOTAL) > 8) ? $clog2(V_TOTAL) : 8;
    localparam int unsigned BAR_W   = ((H_ACTIVE / 8) > 0) ? (H_ACTIVE / 8) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state, state_nx;
    logic [HW-1:0]  h, h_nx;
    logic [VW-1:0]  v, v_nx;
    logic           latch;
    logic           frame_wrap;
    logic [1:0]     sel_q;
    logic [23:0]    solid_q;

    logic           run_c, act_c, hs_on_c, vs_on_c, sof_c;
    logic [HW-1:0]  bar_div_c;
    logic [2:0]     bar_idx_c;
    logic [7:0]     grad_r_c;
    logic [23:0]    bar_rgb_c, pat_rgb_c, rgb_c;

    // State, raster counters and the per-frame pattern latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            h       <= '0;
            v       <= '0;
            sel_q   <= '0;
            solid_q <= '0;
        end else begin
            state <= state_nx;
            h     <= h_nx;
            v     <= v_nx;
            if (latch) begin
                sel_q   <= i_pattern_sel;
                solid_q <= i_solid_rgb;
            end
        end
    end

    // Next state and counter advance; a frame only ends at its last count
    always_comb begin
        state_nx   = state;
        h_nx       = h;
        v_nx       = v;
        latch      = 1'b0;
        frame_wrap = 1'b0;
        case (state)
            IDLE: begin
                h_nx = '0;
                v_nx = '0;
                if (i_enable) begin
                    latch    = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (h == HW'(H_TOTAL - 1)) begin
                    h_nx = '0;
                    if (v == VW'(V_TOTAL - 1)) begin
                        v_nx = '0;
                        if (i_enable) begin
                            latch      = 1'b1;
                            frame_wrap = 1'b1;
                        end else begin
                            state_nx = IDLE;
                        end
                    end else begin
                        v_nx = v + VW'(1);
                    end
                end else begin
                    h_nx = h + HW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

`ifdef TPG_SCROLL_EN
    logic [7:0] frame_cnt;

    // Frame counter: advances at each frame wrap, cleared while idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (state == IDLE) begin
            frame_cnt <= '0;
        end else if (frame_wrap) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end

    // Scrolled gradient red channel and bar index
    always_comb begin
        bar_div_c = h / HW'(BAR_W);
        bar_idx_c = (bar_div_c > HW'(7)) ? 3'd7 : 3'(bar_div_c);
        bar_idx_c = bar_idx_c + frame_cnt[2:0];
        grad_r_c  = 8'(h) + frame_cnt;
    end
`else
    // Static gradient red channel and bar index; remainder pixels stay in bar 7
    always_comb begin
        bar_div_c = h / HW'(BAR_W);
        bar_idx_c = (bar_div_c > HW'(7)) ? 3'd7 : 3'(bar_div_c);
        grad_r_c  = 8'(h);
    end
`endif

    // Raster regions and pattern selection for the current count
    always_comb begin
        run_c   = (state == RUN);
        act_c   = run_c && (h < HW'(H_ACTIVE)) && (v < VW'(V_ACTIVE));
        hs_on_c = run_c && (h >= HW'(H_ACTIVE + H_FP)) && (h < HW'(H_ACTIVE + H_FP + H_SYNC));
        vs_on_c = run_c && (v >= VW'(V_ACTIVE + V_FP)) && (v < VW'(V_ACTIVE + V_FP + V_SYNC));
        sof_c   = run_c && (h == '0) && (v == '0);
        case (bar_idx_c)
            3'd0:    bar_rgb_c = 24'hFFFFFF;
            3'd1:    bar_rgb_c = 24'hFFFF00;
            3'd2:    bar_rgb_c = 24'h00FFFF;
            3'd3:    bar_rgb_c = 24'h00FF00;
            3'd4:    bar_rgb_c = 24'hFF00FF;
            3'd5:    bar_rgb_c = 24'hFF0000;
            3'd6:    bar_rgb_c = 24'h0000FF;
            default: bar_rgb_c = 24'h000000;
        endcase
        case (sel_q)
            2'd0:    pat_rgb_c = bar_rgb_c;
            2'd1:    pat_rgb_c = {grad_r_c, 8'(v), 8'(h) + 8'(v)};
            2'd2:    pat_rgb_c = (h[5] ^ v[5]) ? 24'hFFFFFF : 24'h000000;
            default: pat_rgb_c = solid_q;
        endcase
        rgb_c = act_c ? pat_rgb_c : 24'h000000;
    end

    // Output register: everything for a given count appears one clock later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_rgb888 <= '0;
            o_vaild  <= 1'b0;
            o_sof    <= 1'b0;
            o_hsync  <= ~HS_POL;
            o_vsync  <= ~VS_POL;
        end else begin
            o_rgb888 <= rgb_c;
            o_vaild  <= act_c;
            o_sof    <= sof_c;
            o_hsync  <= hs_on_c ? HS_POL : ~HS_POL;
            o_vsync  <= vs_on_c ? VS_POL : ~VS_POL;
        end
    end

endmodule

// File: tb/tb_vid_tpg_timing.sv
// Directed bench for vid_tpg_timing: a small 22x7 raster for timing and patterns,
// plus a 64x64-active instance for the checker pattern.
module tb_vid_tpg_timing;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        a_en, b_en;
    logic [1:0]  a_sel, b_sel;
    logic [23:0] a_solid, b_solid;
    logic [23:0] a_rgb, b_rgb;
    logic        a_vs, a_hs, a_vaild, a_sof;
    logic        b_vs, b_hs, b_vaild, b_sof;

    int n_checks = 0;
    int n_fail   = 0;
    logic [23:0] g_pix;

    vid_tpg_timing #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut_a (
        .clk(clk), .rst(rst), .i_enable(a_en), .i_pattern_sel(a_sel),
        .i_solid_rgb(a_solid), .o_rgb888(a_rgb), .o_vsync(a_vs),
        .o_hsync(a_hs), .o_vaild(a_vaild), .o_sof(a_sof)
    );

    vid_tpg_timing #(
        .H_ACTIVE(64), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(64), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut_b (
        .clk(clk), .rst(rst), .i_enable(b_en), .i_pattern_sel(b_sel),
        .i_solid_rgb(b_solid), .o_rgb888(b_rgb), .o_vsync(b_vs),
        .o_hsync(b_hs), .o_vaild(b_vaild), .o_sof(b_sof)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] bar_col(input int idx);
        case (idx)
            0:       return 24'hFFFFFF;
            1:       return 24'hFFFF00;
            2:       return 24'h00FFFF;
            3:       return 24'h00FF00;
            4:       return 24'hFF00FF;
            5:       return 24'hFF0000;
            6:       return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    // Expected pixel of the small raster (16x4 active)
    function automatic logic [23:0] exp_rgb(input int sel, input logic [23:0] solid,
                                            input int h, input int v, input int frame);
        int idx;
        int sc;
        sc = frame;
`ifndef TPG_SCROLL_EN
        sc = 0;
`endif
        if (h >= 16 || v >= 4) return 24'h000000;
        case (sel)
            0: begin
                idx = h / 2;
                if (idx > 7) idx = 7;
                return bar_col((idx + sc) % 8);
            end
            1:       return {8'(h + sc), 8'(v), 8'(h + v)};
            2:       return ((((h >> 5) ^ (v >> 5)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
            default: return solid;
        endcase
    endfunction

    // Walk one full frame, starting with the outputs showing (0,0)
    task automatic run_frame(input int sel, input logic [23:0] solid, input int frame,
                             input int chg_at, input logic [1:0] nsel,
                             input logic [23:0] nsolid, input int drop_at);
        int h;
        int v;
        for (int i = 0; i < 154; i++) begin
            h = i % 22;
            v = i / 22;
            check($sformatf("vaild h=%0d v=%0d f=%0d", h, v, frame), 32'(a_vaild),
                  32'((h < 16) && (v < 4)));
            check($sformatf("hsync h=%0d v=%0d f=%0d", h, v, frame), 32'(a_hs),
                  32'((h >= 18) && (h < 20)));
            check($sformatf("vsync h=%0d v=%0d f=%0d", h, v, frame), 32'(a_vs), 32'(v == 5));
            check($sformatf("sof h=%0d v=%0d f=%0d", h, v, frame), 32'(a_sof), 32'(i == 0));
            check($sformatf("rgb h=%0d v=%0d f=%0d", h, v, frame), 32'(a_rgb),
                  32'(exp_rgb(sel, solid, h, v, frame)));
            if (h == 5 && v == 2) g_pix = a_rgb;
            if (i == chg_at) begin
                a_sel   = nsel;
                a_solid = nsolid;
            end
            if (i == drop_at) a_en = 1'b0;
            tick();
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_rgb"},   32'(a_rgb),   32'h0);
        check({tag, "_vaild"}, 32'(a_vaild), 32'h0);
        check({tag, "_sof"},   32'(a_sof),   32'h0);
        check({tag, "_hsync"}, 32'(a_hs),    32'h0);
        check({tag, "_vsync"}, 32'(a_vs),    32'h0);
    endtask

    initial begin
        int cnt;
        int sofs;
        rst = 1'b1; a_en = 1'b0; a_sel = 2'd0; a_solid = 24'h0;
        b_en = 1'b0; b_sel = 2'd2; b_solid = 24'h0;
        g_pix = 24'h0;
        tick(); tick();
        check_idle("reset");
        rst = 1'b0;
        tick();
        check_idle("idle_no_enable");

        // Enable with colour bars: o_sof one clock after RUN entry
        a_en = 1'b1; a_sel = 2'd0;
        tick();
        check("run_entry_sof", 32'(a_sof), 32'h0);
        check("run_entry_vaild", 32'(a_vaild), 32'h0);
        tick();
        check("first_pixel_bar0", 32'(a_rgb), 32'hFFFFFF);
        run_frame(0, 24'h0, 0, 3, 2'd1, 24'h0, -1);
        run_frame(1, 24'h0, 1, 50, 2'd3, 24'h123456, -1);
`ifdef TPG_SCROLL_EN
        check("gradient_h5_v2", 32'(g_pix), 32'h060207);
`else
        check("gradient_h5_v2", 32'(g_pix), 32'h050207);
`endif
        // Solid frame with selection changed mid-frame to bars
        run_frame(3, 24'h123456, 2, 60, 2'd0, 24'hABCDEF, -1);
        run_frame(0, 24'hABCDEF, 3, 10, 2'd2, 24'h0, -1);
        // Enable dropped mid-frame: frame still completes, then IDLE
        run_frame(2, 24'h0, 4, -1, 2'd0, 24'h0, 40);
        check_idle("after_drop");
        tick(); tick(); tick();
        check_idle("idle_hold");

        // Re-enable and measure the sof period
        a_en = 1'b1; a_sel = 2'd0;
        tick();
        check("reen_sof_early", 32'(a_sof), 32'h0);
        tick();
        check("reen_sof", 32'(a_sof), 32'h1);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!a_sof && cnt < 300);
        check("sof_period", 32'(cnt), 32'd154);

        // Asynchronous reset mid-line
        tick(); tick(); tick(); tick(); tick();
        check("pre_reset_vaild", 32'(a_vaild), 32'h1);
        #3;
        rst = 1'b1;
        #1;
        check_idle("async_reset");
        a_en = 1'b0;
        tick();
        rst = 1'b0;
        sofs = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (a_sof) sofs++;
        end
        check("no_sof_after_reset", 32'(sofs), 32'h0);
        a_en = 1'b1;
        tick(); tick();
        check("sof_after_reenable", 32'(a_sof), 32'h1);

        // Checker on the 64x64 raster
        b_en = 1'b1; b_sel = 2'd2;
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!b_sof && cnt < 50);
        check("chk_sof_seen", 32'(b_sof), 32'h1);
        for (int i = 0; i < 31; i++) tick();
        check("chk_h31_v0", 32'(b_rgb), 32'h000000);
        tick();
        check("chk_h32_v0", 32'(b_rgb), 32'hFFFFFF);
        for (int i = 0; i < 32 * 67; i++) tick();
        check("chk_h32_v32", 32'(b_rgb), 32'h000000);
        check("chk_h32_v32_vaild", 32'(b_vaild), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vid_tpg_timing.md
Name: vid_tpg_timing

Overview:
- Video timing generator and test-pattern source. Sits directly upstream of the per-channel gamma stage and drives its RGB888 / vsync / hsync / vaild inputs.
- Produces a parameterised raster (active, front porch, sync, back porch) with one of four selectable patterns.
- Used for bring-up and for checking the gamma pipeline with no sensor attached.

Parameters:
- H_ACTIVE, 1280, active pixels per line
- H_FP, 110, horizontal front porch in clocks
- H_SYNC, 40, hsync width in clocks
- H_BP, 220, horizontal back porch in clocks
- V_ACTIVE, 720, active lines per frame
- V_FP, 5, vertical front porch in lines
- V_SYNC, 5, vsync width in lines
- V_BP, 20, vertical back porch in lines
- HS_POL, 1, hsync active level
- VS_POL, 1, vsync active level

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset, asynchronous, active-high
- i_enable  in  1  run request
- i_pattern_sel  in  2  0 colour bars, 1 gradient, 2 checker, 3 solid
- i_solid_rgb  in  24  solid colour {R,G,B}
- o_rgb888  out  24  pixel {R[23:16],G[15:8],B[7:0]}
- o_vsync  out  1  vertical sync
- o_hsync  out  1  horizontal sync
- o_vaild  out  1  active-pixel qualifier
- o_sof  out  1  one-cycle pulse on first active pixel of a frame

Behaviour:
- Clock and reset: single clock domain, clk. Reset is asynchronous and active-high, port rst.
- Reset values: o_rgb888=0, o_vaild=0, o_sof=0, o_hsync=~HS_POL, o_vsync=~VS_POL. Counters reset to h=0, v=0; state goes to IDLE.
- Reset asserted mid-frame: all outputs and state take reset values immediately (asynchronous).
- Counters:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
  - h counts 0..H_TOTAL-1 and wraps to 0. v increments when h wraps, and counts 0..V_TOTAL-1.
  - Region order is active, FP, sync, BP, measured from count 0.
  - Active means h<H_ACTIVE and v<V_ACTIVE.
  - hsync is active for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC. vsync uses the same rule on v, for whole lines.
- State machine:
  - IDLE: counters held at 0; outputs at reset values. When i_enable=1, latch pattern_sel and solid_rgb, then go to RUN. The counters start at (0,0) on the next cycle.
  - RUN: counters advance every clock. On the last count of the frame (h=H_TOTAL-1, v=V_TOTAL-1):
    - if i_enable=1, wrap to (0,0) and relatch pattern_sel and solid_rgb;
    - otherwise go to IDLE.
  - Deasserting i_enable mid-frame never truncates the frame.
- Pattern select: i_pattern_sel and i_solid_rgb are used only at frame boundaries. Changes mid-frame take effect from the next frame.
- Latency: the outputs for counter value (h,v) are registered and appear exactly 1 clock later. rgb, syncs, vaild and sof are mutually aligned.
- o_rgb888 is 0 whenever o_vaild=0.
- Patterns (active region only):
  - Colour bars: BAR_W = H_ACTIVE/8, integer division. idx = h/BAR_W, clamped to 7 so remainder pixels stay in bar 7. Bar colours 0..7: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - Gradient: R=h[7:0] (plus offset, see Optional Feature), G=v[7:0], B=(h+v)[7:0]. All 8-bit wrap.
  - Checker: h[5]^v[5] ? FFFFFF : 000000.
  - Solid: the latched solid_rgb value.
- o_sof: high with the output for (h=0, v=0) while in RUN.

Optional Feature:
- Macro: TPG_SCROLL_EN.
- Defined: an 8-bit frame counter increments at every frame wrap and clears to 0 on reset and in IDLE. The gradient R channel becomes (h+frame_cnt)[7:0], and the colour-bar idx becomes ((h/BAR_W clamped)+frame_cnt[2:0]) mod 8.
- Not defined: no counter; patterns are static exactly as listed under Behaviour.

Test Plan (parameters H_ACTIVE=16, H_FP=2, H_SYNC=2, H_BP=2, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1, so H_TOTAL=22, V_TOTAL=7, 154 clocks/frame):
- Reset then enable=1, sel=0 -> o_sof one clock after RUN entry; 16 vaild pixels per line, 4 lines per frame; pixels 0-1 FFFFFF, 2-3 FFFF00, …, 14-15 000000.
- Sync timing -> hsync at level HS_POL for h=18..19 (2 clocks per line); vsync at level VS_POL for all of v=5; vaild=0 and rgb=0 in every porch/sync cycle; 154 clocks between consecutive o_sof pulses.
- sel=1 -> line v=2, pixel h=5: rgb=05_02_07. sel=2 with H_ACTIVE=64: h=32,v=0 gives FFFFFF; h=32,v=32 gives 000000.
- sel changed 3→0 mid-frame with solid=123456 -> rest of that frame stays 123456; next frame shows bars.
- enable dropped mid-frame -> frame completes through (21,6), then IDLE with outputs at reset levels; re-enable -> next o_sof 2 clocks after enable is sampled. rst pulsed mid-line -> outputs go to reset values immediately, no o_sof until re-enabled.
- TPG_SCROLL_EN defined, sel=1 -> frame 3, pixel h=0 gives R=03; bars in frame 1 shift by one (pixel 0 = FFFF00).
